// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int FRAME_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_t;

  // Even-parity bit of a byte, forced to 0 when parity is disabled so the
  // transmitter and receiver agree on the slot contents in both modes.
  function automatic logic par8(input logic [7:0] data, input logic en);
    return (^data) & en;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: emits a tick at the first half period after clear, then every T clocks.
// Latency: tick is combinational from the count; first tick T/2-1 counts after the clear cycle.
// Backpressure: none; counts only while i_en is high, holds otherwise.
module uart_baud_cnt #(
  parameter int T  = 10,
  parameter int CW = 13
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_half,
  output logic o_tick
);

  logic [CW-1:0] r_cnt;
  logic          r_first;
  logic [CW-1:0] w_limit;

  // The first interval after a clear is half a bit, so ticks land mid-bit.
  assign w_limit = r_first ? CW'(T/2 - 1) : CW'(T - 1);
  assign o_tick  = i_en && !i_clr && (r_cnt == w_limit);

  // Count up to the current limit, wrap to zero and drop the half-period flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_first <= i_half;
    end else if (i_en) begin
      if (r_cnt == w_limit) begin
        r_cnt   <= '0;
        r_first <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, parity slot, one stop bit; writes good bytes to the RX FIFO.
// Latency: write/error pulse one clock after the stop-bit mid sample (mid sample itself lags the pin by 2 sync flops).
// Backpressure: full is sampled only at the stop sample; a good byte arriving while full is dropped with an overrun pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int F_CLK     = 50_000_000,
  parameter int BAUD      = 9600,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RXD,
  input  logic       full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_data_in,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int T  = F_CLK / BAUD;
  localparam int CW = ($clog2(T) > 13) ? $clog2(T) : 13;

  logic        r_sync1;
  logic        r_rxd_s;
  logic        r_rxd_prev;
  logic        w_fall;

  uart_state_t r_state;
  uart_state_t w_next;

  logic [7:0]  r_shift;
  logic [2:0]  r_bit_idx;
  logic        r_par_bit;

  logic        w_tick;
  logic        w_cnt_clr;
  logic        w_cnt_en;
  logic        w_shift_en;
  logic        w_par_ld;
  logic        w_par_bad;
  logic        w_wr;
  logic        w_ferr;
  logic        w_perr;
  logic        w_ovr;

  logic        r_wr_en;
  logic [7:0]  r_data;
  logic        r_ferr;
  logic        r_perr;
  logic        r_ovr;

  // Bring RXD into the clock domain and keep one extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_sync1    <= RXD;
      r_rxd_s    <= r_sync1;
      r_rxd_prev <= r_rxd_s;
    end
  end

  assign w_fall = r_rxd_prev & ~r_rxd_s;

  // With parity disabled both sides collapse to 0, so the check never fires.
  assign w_par_bad = ((r_par_bit & PARITY_EN) != par8(r_shift, PARITY_EN));

  uart_baud_cnt #(
    .T  (T),
    .CW (CW)
  ) u_baud (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_half (1'b1),
    .o_tick (w_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: every bit decision is taken at the mid-bit tick.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_fall) w_next = START;
      START:     if (w_tick) w_next = r_rxd_s ? IDLE : DATA;
      DATA:      if (w_tick && (r_bit_idx == 3'(FRAME_DATA_BITS - 1))) w_next = PARITY;
      PARITY:    if (w_tick) w_next = STOP;
      STOP:      if (w_tick) w_next = r_rxd_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (r_rxd_s) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Per-state controls; stop-bit checks are prioritised framing > parity > overrun.
  always_comb begin
    w_cnt_clr  = 1'b0;
    w_cnt_en   = (r_state != IDLE);
    w_shift_en = 1'b0;
    w_par_ld   = 1'b0;
    w_wr       = 1'b0;
    w_ferr     = 1'b0;
    w_perr     = 1'b0;
    w_ovr      = 1'b0;
    case (r_state)
      IDLE:   w_cnt_clr  = w_fall;
      DATA:   w_shift_en = w_tick;
      PARITY: w_par_ld   = w_tick;
      STOP: begin
        if (w_tick) begin
          if (!r_rxd_s)       w_ferr = 1'b1;
          else if (w_par_bad) w_perr = 1'b1;
          else if (full)      w_ovr  = 1'b1;
          else                w_wr   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath: shift register, parity latch and registered single-cycle outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_par_bit <= 1'b0;
      r_wr_en   <= 1'b0;
      r_data    <= '0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_wr_en <= w_wr;
      r_ferr  <= w_ferr;
      r_perr  <= w_perr;
      r_ovr   <= w_ovr;
      if (w_wr) begin
        r_data <= r_shift;
      end
      if (w_cnt_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_shift   <= {r_rxd_s, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_par_ld) begin
        r_par_bit <= r_rxd_s;
      end
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data;
  assign frame_err    = r_ferr;
  assign parity_err   = r_perr;
  assign overrun      = r_ovr;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receives asynchronous serial frames on RXD and pushes each good byte into the receive FIFO.
- Frame is idle-high, 11 bits: start (0), 8 data bits LSB first, one parity slot, stop (1). This matches the team's uart_tx frame format.
- Sits between the board RX pin and the RX FIFO write port, running on the system clock.
- Reports framing, parity and overrun errors as single-cycle pulses.

Parameters:
- F_CLK, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- T, F_CLK/BAUD, clocks per bit. Derived; do not override independently.
- PARITY_EN, 1. When 1, the parity bit must equal XOR of the 8 data bits. When 0, the parity slot is sampled and ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- RXD  in  1  asynchronous serial input, idle high
- full  in  1  RX FIFO full flag
- fifo_wr_en  out  1  one-cycle write strobe to the FIFO
- fifo_data_in  out  8  received byte; valid while fifo_wr_en=1
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- parity_err  out  1  one-cycle pulse: parity mismatch (PARITY_EN=1 only)
- overrun  out  1  one-cycle pulse: good byte dropped because full=1

Behaviour:
- Reset: rst is sampled on the clk edge. It forces state IDLE and clears the bit counter, bit index and shift register. Reset values: fifo_wr_en=0, fifo_data_in=8'h00, frame_err=0, parity_err=0, overrun=0. Synchronizer flops reset to 1. rst asserted mid-frame aborts the frame with no write and no error pulse.
- Synchronizer: RXD passes through a 2-flop synchronizer (rxd_s). A falling edge is rxd_s=0 with the previous value 1.
- Baud counter: 13 bits minimum, sized as clog2(T). It runs only outside IDLE and wraps at T-1.
- Sample points: the middle of each bit, i.e. the first sample at count T/2-1 after the edge, then every T clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on a falling edge go to START and clear the counter.
  - START: at the mid-bit sample, rxd_s=0 goes to DATA. rxd_s=1 is a false start: return to IDLE with no pulse.
  - DATA: shift rxd_s into bit 7 of the shift register, shifting right (LSB first). After the 8th sample go to PARITY.
  - PARITY: latch the sampled bit and go to STOP.
  - STOP: at the sample, evaluate the checks in this priority order:
    - rxd_s=0: frame_err pulse, no write, go to WAIT_HIGH.
    - PARITY_EN=1 and parity bit != ^data: parity_err pulse, no write, go to IDLE.
    - full=1: overrun pulse, no write, go to IDLE.
    - otherwise: fifo_wr_en=1 and fifo_data_in=data, go to IDLE.
  - WAIT_HIGH: stay until rxd_s=1 (break/line-low condition), then IDLE.
- Latency: fifo_wr_en and the error pulses assert in the clock after the stop-bit mid sample and last exactly one cycle.
- fifo_data_in holds its last value between writes.
- The 2-flop synchronizer adds 2 clocks of fixed delay to every sample point.
- At most one of fifo_wr_en, frame_err, parity_err or overrun asserts per frame.
- Back-to-back frames: returning to IDLE at the stop-bit mid sample leaves half a bit to catch the next start edge. Zero idle time between frames must be received correctly.
- full is sampled only at the stop sample; full toggling mid-frame has no effect.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum.
  - FRAME_DATA_BITS=8.
  - Parity function par8(data, en), which returns (^data)&en. uart_tx should share it.
- One natural sub-module, uart_baud_cnt: counter with a start/clear input, a half-period first-tick option, and a tick output.
- Synchronizer and FSM stay in uart_rx.

Test Plan:
- Use F_CLK=50_000_000, BAUD=5_000_000 (T=10) throughout.
- Send 0xA5 with parity 0 and stop 1 -> one fifo_wr_en pulse with fifo_data_in=0xA5 in the clock after the stop mid sample; no error pulses.
- Send 0x3C, then 0xFF with zero idle between them -> two writes, 0x3C then 0xFF (parity bit 0 for both).
- Low glitch of 3 clocks on an idle line -> START rejects it, no pulses, FSM back in IDLE.
- Send 0x01 with parity bit 0 -> parity_err pulse, no write. Same frame with PARITY_EN=0 -> write of 0x01.
- Send 0x55 with stop bit 0, then hold RXD low for 30 clocks -> frame_err pulse once, FSM stays in WAIT_HIGH until RXD rises, and the next frame 0x12 is received.
- Hold full=1 and send 0x77 -> overrun pulse, no write.
- Assert rst for 1 cycle during data bit 4 -> outputs stay 0, no write, and the next frame 0x9E is received correctly.
